sram_like_responder: RTL and testbench

//  Slave (responder) end of the CPU's two sram-like channels: answers inst_* and data_* requests from a local word RAM.

---
 rtl/sram_like_responder_if.sv | 46 ++++
 rtl/sram_like_responder.sv | 126 ++++++++++++
 tb/tb_sram_like_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_responder_if.sv
// rtl/sram_like_responder_if.sv - inst/data sram-like channel bundle between a CPU and its responder
//
// Purpose: groups both sram-like channels into one bundle.
//   master modport: CPU side (drives requests, receives handshakes and read data)
//   slave modport : responder side (receives requests, drives handshakes and read data)
// Signals:
//   inst_req/inst_wr/inst_size/inst_addr/inst_wdata -> inst request
//   inst_rdata/inst_addr_ok/inst_data_ok            <- inst handshakes and read data
//   data_req/data_wr/data_size/data_strb/data_addr/data_wdata -> data request
//   data_rdata/data_raddr_ok/data_waddr_ok/data_rdata_ok/data_wdata_ok <- data handshakes and read data
interface sram_like_responder_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_strb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_raddr_ok;
  logic        data_waddr_ok;
  logic        data_rdata_ok;
  logic        data_wdata_ok;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_strb, data_addr, data_wdata,
    input  data_rdata, data_raddr_ok, data_waddr_ok, data_rdata_ok, data_wdata_ok
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_strb, data_addr, data_wdata,
    output data_rdata, data_raddr_ok, data_waddr_ok, data_rdata_ok, data_wdata_ok
  );
endinterface

// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - word-RAM responder for the CPU inst/data sram-like channels
//
// Purpose: accepts at most one request per cycle (data before inst), performs the RAM
//   access at the acceptance edge and answers each channel in order after LATENCY edges,
//   with at most DEPTH outstanding responses per channel.
// Ports:
//   clk    in  clock
//   resetn in  synchronous active-low reset (drops all outstanding responses)
//   bus    slave modport of sram_like_responder_if (both channels)
// Optional feature: define RESP_RANDOM_STALL_EN to refuse all requests in cycles where
//   a free-running 16-bit LFSR has its two low bits clear.
module sram_like_responder #(
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 2,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_like_responder_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

  logic [31:0]   mem [2**ADDR_W];

  // Per-channel response queues: index 0 = inst, 1 = data.
  logic          q_wr [2][DEPTH];
  logic [31:0]   q_rd [2][DEPTH];
  logic [3:0]    q_cd [2][DEPTH];
  logic [PW-1:0] head [2];
  logic [PW-1:0] tail [2];
  logic [CW-1:0] cnt  [2];
  logic [31:0]   last_rd [2];
  logic [31:0]   head_rd [2];
  logic [1:0]    head_wr, pop, push, room;

  logic              stall, grant_d, grant_i, acc_en, acc_wr;
  logic [ADDR_W-1:0] acc_idx;
  logic [3:0]        acc_strb;
  logic [31:0]       acc_wdata;
  logic              unused_bits;

`ifdef RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    int s;
    s = 0;
    for (int c = 0; c < 2; c++) begin
      head_wr[c] = q_wr[c][head[c]];
      head_rd[c] = head_wr[c] ? 32'h0 : q_rd[c][head[c]];
      pop[c]     = resetn && (cnt[c] != '0) && (q_cd[c][head[c]] == 4'd0);
      // A slot freed by this cycle's pop can be refilled on the same edge.
      room[c]    = (cnt[c] - CW'(pop[c])) < CW'(DEPTH);
      s = int'(head[c]) + int'(cnt[c]);
      if (s >= DEPTH) s = s - DEPTH;
      tail[c]    = PW'(s);
    end
    grant_d   = resetn && !stall && bus.data_req && room[1];
    grant_i   = resetn && !stall && bus.inst_req && !grant_d && room[0];
    push      = {grant_d, grant_i};
    acc_en    = grant_d || grant_i;
    acc_wr    = grant_d ? bus.data_wr : bus.inst_wr;
    acc_idx   = grant_d ? bus.data_addr[ADDR_W+1:2] : bus.inst_addr[ADDR_W+1:2];
    acc_strb  = grant_d ? bus.data_strb : 4'hF;
    acc_wdata = grant_d ? bus.data_wdata : bus.inst_wdata;
  end

  always_ff @(posedge clk) begin
    if (acc_en && acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_strb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int c = 0; c < 2; c++) begin
        head[c]    <= '0;
        cnt[c]     <= '0;
        last_rd[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (q_cd[c][e] != 4'd0) q_cd[c][e] <= q_cd[c][e] - 4'd1;
        end
        // Only one access per edge, so the read never races a write to the same word.
        if (push[c]) begin
          q_wr[c][tail[c]] <= acc_wr;
          q_rd[c][tail[c]] <= acc_wr ? 32'h0 : mem[acc_idx];
          q_cd[c][tail[c]] <= CD_INIT;
        end
        if (pop[c]) begin
          head[c]    <= (head[c] == PW'(DEPTH - 1)) ? '0 : head[c] + 1'b1;
          last_rd[c] <= head_rd[c];
        end
        cnt[c] <= cnt[c] + CW'(push[c]) - CW'(pop[c]);
      end
    end
  end

  assign bus.inst_addr_ok  = grant_i;
  assign bus.data_raddr_ok = grant_d && !bus.data_wr;
  assign bus.data_waddr_ok = grant_d && bus.data_wr;
  assign bus.inst_data_ok  = pop[0];
  assign bus.data_rdata_ok = pop[1] && !head_wr[1];
  assign bus.data_wdata_ok = pop[1] && head_wr[1];
  assign bus.inst_rdata    = pop[0] ? head_rd[0] : last_rd[0];
  assign bus.data_rdata    = pop[1] ? head_rd[1] : last_rd[1];

  assign unused_bits = ^{bus.inst_size, bus.data_size,
                         bus.inst_addr[31:ADDR_W+2], bus.inst_addr[1:0],
                         bus.data_addr[31:ADDR_W+2], bus.data_addr[1:0], LFSR_SEED};
endmodule

// File: tb/tb_sram_like_responder.sv
// tb/tb_sram_like_responder.sv - self-checking bench for sram_like_responder
module tb_sram_like_responder;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_like_responder_if bus();
  sram_like_responder_if bus8();

  sram_like_responder #(.ADDR_W(12), .LATENCY(LAT), .DEPTH(DEP), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));
  sram_like_responder #(.ADDR_W(12), .LATENCY(8), .DEPTH(4), .LFSR_SEED(16'hACE1)) dut8 (
    .clk(clk), .resetn(resetn), .bus(bus8));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        d_req, d_wr;
    logic [3:0]  d_strb;
    logic [31:0] d_addr, d_wdata;
    logic        i_req, i_wr;
    logic [31:0] i_addr, i_wdata;
    logic [5:0]  e_ok;   // {inst_addr_ok, inst_data_ok, raddr_ok, waddr_ok, rdata_ok, wdata_ok}
    logic [31:0] e_drd, e_ird;
  } vec_t;

  typedef struct {
    int          due;
    logic        wr;
    logic [31:0] rd;
  } ent_t;

  vec_t tv[17];
  ent_t mq_i[$];
  ent_t mq_d[$];
  logic [31:0] mm [int];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, didx, iidx, k;
    logic dreq, dwr, ireq, iwr, stall, pd, pi, gd, gi;
    logic [3:0] dstrb;
    logic [31:0] daddr, dwd, iaddr, iwd, rv, w;
    logic [15:0] mlfsr;

    bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 2; bus.inst_addr = 0; bus.inst_wdata = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2; bus.data_strb = 4'hF;
    bus.data_addr = 0; bus.data_wdata = 0;
    bus8.inst_req = 0; bus8.inst_wr = 0; bus8.inst_size = 2; bus8.inst_addr = 0; bus8.inst_wdata = 0;
    bus8.data_req = 0; bus8.data_wr = 0; bus8.data_size = 2; bus8.data_strb = 4'hF;
    bus8.data_addr = 0; bus8.data_wdata = 0;

`ifndef RESP_RANDOM_STALL_EN
    // rst, dreq, dwr, strb, daddr, dwdata, ireq, iwr, iaddr, iwdata, exp ok, exp drdata, exp irdata
    tv[0]  = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        6'b000000, 32'h0,        32'h0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        6'b000000, 32'h0,        32'h0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        6'b000000, 32'h0,        32'h0};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344, 1'b1, 1'b0, 32'h20, 32'h0,        6'b000100, 32'h0,        32'h0};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 4'h3, 32'h10, 32'hAABBCCDD, 1'b0, 1'b0, 32'h20, 32'h0,        6'b000100, 32'h0,        32'h0};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        1'b0, 1'b0, 32'h20, 32'h0,        6'b001001, 32'h0,        32'h0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        6'b000001, 32'h0,        32'h0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        6'b000010, 32'h1122CCDD, 32'h0};
    tv[8]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        6'b001000, 32'h0,        32'h0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        6'b100000, 32'h0,        32'h0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        6'b000010, 32'h1122CCDD, 32'h0};
    tv[11] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        6'b010000, 32'h0,        32'h1122CCDD};
    tv[12] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 6'b100000, 32'h0,        32'h0};
    tv[13] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        6'b100000, 32'h0,        32'h0};
    tv[14] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        6'b010000, 32'h0,        32'h0};
    tv[15] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        6'b010000, 32'h0,        32'hDEADBEEF};
    tv[16] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        6'b000000, 32'h0,        32'h0};

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      resetn = tv[i].rst_n;
      bus.data_req = tv[i].d_req; bus.data_wr = tv[i].d_wr; bus.data_strb = tv[i].d_strb;
      bus.data_addr = tv[i].d_addr; bus.data_wdata = tv[i].d_wdata;
      bus.inst_req = tv[i].i_req; bus.inst_wr = tv[i].i_wr;
      bus.inst_addr = tv[i].i_addr; bus.inst_wdata = tv[i].i_wdata;
      #1;
      chk($sformatf("vec%0d_ok", i),
          {bus.inst_addr_ok, bus.inst_data_ok, bus.data_raddr_ok, bus.data_waddr_ok,
           bus.data_rdata_ok, bus.data_wdata_ok}, tv[i].e_ok);
      if (tv[i].e_ok[1]) chk($sformatf("vec%0d_data_rdata", i), bus.data_rdata, tv[i].e_drd);
      if (tv[i].e_ok[4]) chk($sformatf("vec%0d_inst_rdata", i), bus.inst_rdata, tv[i].e_ird);
    end

    // Outstanding limit with long latency: four accepts, then refused until the first pop.
    @(negedge clk);
    bus8.inst_req = 1; bus8.inst_wr = 0; bus8.inst_addr = 32'h100;
    for (k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("full_k%0d", k), {bus8.inst_addr_ok, bus8.inst_data_ok},
          {(k < 4) || (k >= 8), k >= 8});
      @(negedge clk);
    end
    bus8.inst_req = 0;

    // Reset with three reads outstanding drops them all.
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    bus8.data_req = 1; bus8.data_wr = 0; bus8.data_addr = 32'h40;
    for (k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pre_rst_raddr_ok%0d", k), bus8.data_raddr_ok, 1'b1);
      @(negedge clk);
    end
    bus8.data_req = 0;
    resetn = 0;
    #1;
    chk("ok_during_reset", {bus8.data_raddr_ok, bus8.data_rdata_ok, bus8.inst_data_ok}, 3'b000);
    @(negedge clk);
    resetn = 1;
    #1;
    chk("rdata_after_reset", bus8.data_rdata, 32'h0);
    for (k = 0; k < 12; k++) begin
      chk($sformatf("no_resp_after_reset%0d", k),
          {bus8.inst_data_ok, bus8.data_rdata_ok, bus8.data_wdata_ok}, 3'b000);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    bus8.data_req = 1; bus8.data_wr = 1; bus8.data_strb = 4'hF; bus8.data_addr = 32'h40;
    for (k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("count_cleared%0d", k), bus8.data_waddr_ok, 1'b1);
      @(negedge clk);
    end
    bus8.data_req = 0;
`endif

    // Randomized traffic against a queue/array reference model.
    @(negedge clk);
    bus.data_req = 0; bus.inst_req = 0;
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    cyc = 0;
    mlfsr = 16'hACE1;
    for (int n = 0; n < 400; n++) begin
      dreq = 1'($urandom_range(0, 1)); dwr = 1'($urandom_range(0, 1));
      dstrb = 4'($urandom_range(0, 15)); didx = int'($urandom_range(0, 15));
      daddr = (32'(didx) << 2) | 32'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 32'h0010_0000 : 32'h0);
      dwd = $urandom;
      if (!mm.exists(didx)) begin dwr = 1; dstrb = 4'hF; end
      ireq = 1'($urandom_range(0, 1)); iwr = 1'($urandom_range(0, 3) == 0);
      iidx = int'($urandom_range(0, 15));
      iaddr = (32'(iidx) << 2) | 32'($urandom_range(0, 3));
      iwd = $urandom;
      if (!mm.exists(iidx)) iwr = 1;
      bus.data_req = dreq; bus.data_wr = dwr; bus.data_strb = dstrb;
      bus.data_addr = daddr; bus.data_wdata = dwd;
      bus.inst_req = ireq; bus.inst_wr = iwr; bus.inst_addr = iaddr; bus.inst_wdata = iwd;
      #1;
`ifdef RESP_RANDOM_STALL_EN
      stall = (mlfsr[1:0] == 2'b00);
`else
      stall = 1'b0;
`endif
      pd = (mq_d.size() > 0) && (mq_d[0].due == cyc);
      pi = (mq_i.size() > 0) && (mq_i[0].due == cyc);
      gd = dreq && !stall && ((mq_d.size() - int'(pd)) < DEP);
      gi = ireq && !gd && !stall && ((mq_i.size() - int'(pi)) < DEP);
      chk("rand_addr_ok", {bus.inst_addr_ok, bus.data_raddr_ok, bus.data_waddr_ok},
          {gi, gd && !dwr, gd && dwr});
      chk("rand_data_ok", {bus.inst_data_ok, bus.data_rdata_ok, bus.data_wdata_ok},
          {pi, pd && !mq_d[0].wr, pd && mq_d[0].wr});
      if (pd) begin
        if (!mq_d[0].wr) chk("rand_data_rdata", bus.data_rdata, mq_d[0].rd);
        void'(mq_d.pop_front());
      end
      if (pi) begin
        chk("rand_inst_rdata", bus.inst_rdata, mq_i[0].rd);
        void'(mq_i.pop_front());
      end
      if (gd) begin
        rv = dwr ? 32'h0 : mm[didx];
        if (dwr) begin
          w = mm.exists(didx) ? mm[didx] : 32'h0;
          for (int b = 0; b < 4; b++) if (dstrb[b]) w[8*b +: 8] = dwd[8*b +: 8];
          mm[didx] = w;
        end
        mq_d.push_back('{cyc + LAT, dwr, rv});
      end
      if (gi) begin
        rv = iwr ? 32'h0 : mm[iidx];
        if (iwr) mm[iidx] = iwd;
        mq_i.push_back('{cyc + LAT, iwr, rv});
      end
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
      cyc++;
      @(negedge clk);
    end
    bus.data_req = 0; bus.inst_req = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
